// File: rtl/pipe_control.sv
// Pipelined control unit for the WISC-S25 core.
// Decodes the IF/ID instruction, carries control bits through the EX/MEM/WB
// stage registers, detects load-use hazards, squashes on taken branches and
// drains the pipeline on HLT before reporting halted.
module pipe_control #(
  parameter int          REG_W        = 4,
  parameter int          PIPE_DRAIN   = 3,
  parameter logic [15:0] FLAG_EN_MASK = 16'h0077,
  parameter logic [15:0] REGWR_MASK   = 16'h4DFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      id_instr,
  input  logic             id_valid,
  input  logic             branch_taken,
  output logic             id_rr1_sel,
  output logic             id_rr2_sel,
  output logic [1:0]       id_imm_sel,
  output logic             id_branch,
  output logic             id_branch_reg,
  output logic             stall,
  output logic             flush,
  output logic             pc_hold,
  output logic [3:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic             ex_flag_en,
  output logic             ex_pcs,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_reg_write,
  output logic             ex_mem_to_reg,
  output logic [REG_W-1:0] ex_rd,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             mem_reg_write,
  output logic             mem_mem_to_reg,
  output logic [REG_W-1:0] mem_rd,
  output logic             wb_reg_write,
  output logic             wb_mem_to_reg,
  output logic [REG_W-1:0] wb_rd,
  output logic             halted
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LLB = 4'hA;
  localparam logic [3:0] OP_LHB = 4'hB;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Drain counter wide enough to hold PIPE_DRAIN-1 (at least one bit).
  localparam int                CNT_W    = (PIPE_DRAIN > 1) ? $clog2(PIPE_DRAIN) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(PIPE_DRAIN - 1);

  // Instruction fields
  logic [3:0]       op;
  logic [REG_W-1:0] f_rd;
  logic [REG_W-1:0] f_rs;
  logic [REG_W-1:0] f_rt;

  assign op   = id_instr[15:12];
  assign f_rd = id_instr[8 +: REG_W];
  assign f_rs = id_instr[4 +: REG_W];
  assign f_rt = id_instr[0 +: REG_W];

  // FSM state
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // EX stage control
  logic [3:0]       ex_alu_op_q, ex_alu_op_d;
  logic             ex_alu_src_q, ex_alu_src_d;
  logic             ex_flag_en_q, ex_flag_en_d;
  logic             ex_pcs_q, ex_pcs_d;
  logic             ex_mem_read_q, ex_mem_read_d;
  logic             ex_mem_write_q, ex_mem_write_d;
  logic             ex_reg_write_q, ex_reg_write_d;
  logic             ex_mem_to_reg_q, ex_mem_to_reg_d;
  logic [REG_W-1:0] ex_rd_q, ex_rd_d;

  // MEM stage control
  logic             mem_mem_read_q, mem_mem_read_d;
  logic             mem_mem_write_q, mem_mem_write_d;
  logic             mem_reg_write_q, mem_reg_write_d;
  logic             mem_mem_to_reg_q, mem_mem_to_reg_d;
  logic [REG_W-1:0] mem_rd_q, mem_rd_d;

  // WB stage control
  logic             wb_reg_write_q, wb_reg_write_d;
  logic             wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [REG_W-1:0] wb_rd_q, wb_rd_d;

  // Hazard / sequencing terms
  logic             eff_valid;
  logic             is_hlt;
  logic             is_branch_op;
  logic             halt_accept;
  logic             issue;
  logic [2:0]       src_used;
  logic [2:0]       src_hit;
  logic [REG_W-1:0] src_reg [3];

  // Only a real instruction seen while running is allowed to decode.
  assign eff_valid = id_valid & (state_q == ST_RUN);
  assign is_hlt    = (op == OP_HLT);
  assign is_branch_op = (op == OP_B) | (op == OP_BR);

  // Which instruction fields are read as source registers by this opcode.
  always_comb begin
    src_used    = 3'b000;
    src_used[0] = (op <= 4'd9) | (op == OP_BR);
    src_used[1] = (op == 4'd0) | (op == 4'd1) | (op == 4'd2) | (op == 4'd3) | (op == 4'd7);
    src_used[2] = (op == OP_SW) | (op == OP_LLB) | (op == OP_LHB);
  end

  assign src_reg[0] = f_rs;
  assign src_reg[1] = f_rt;
  assign src_reg[2] = f_rd;

  // Per-source comparison against the load currently in EX (r0 included).
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_src_hit
      assign src_hit[gi] = src_used[gi] & (src_reg[gi] == ex_rd_q);
    end
  endgenerate

  assign stall       = eff_valid & ex_mem_read_q & (|src_hit);
  assign halt_accept = eff_valid & ~stall & is_hlt;
  assign issue       = eff_valid & ~stall & ~is_hlt;

  // ID-stage steering and branch outputs
  assign id_rr1_sel    = eff_valid & ((op == OP_LLB) | (op == OP_LHB));
  assign id_rr2_sel    = eff_valid & (op == OP_SW);
  assign id_branch     = eff_valid & (op == OP_B);
  assign id_branch_reg = eff_valid & (op == OP_BR);
  assign flush         = eff_valid & ~stall & is_branch_op & branch_taken;
  assign pc_hold       = stall | (state_q != ST_RUN) | halt_accept;

  // Immediate format select for the ID-stage extender.
  always_comb begin
    id_imm_sel = 2'b00;
    if (eff_valid) begin
      if ((op == OP_LW) | (op == OP_SW)) begin
        id_imm_sel = 2'b01;
      end else if ((op == OP_LLB) | (op == OP_LHB)) begin
        id_imm_sel = 2'b10;
      end
    end
  end

  // Next EX control: decoded bits on issue, otherwise an all-zero bubble.
  always_comb begin
    ex_alu_op_d     = 4'h0;
    ex_alu_src_d    = 1'b0;
    ex_flag_en_d    = 1'b0;
    ex_pcs_d        = 1'b0;
    ex_mem_read_d   = 1'b0;
    ex_mem_write_d  = 1'b0;
    ex_reg_write_d  = 1'b0;
    ex_mem_to_reg_d = 1'b0;
    ex_rd_d         = '0;
    if (issue) begin
      ex_alu_op_d     = op;
      ex_alu_src_d    = (op == 4'd4) | (op == 4'd5) | (op == 4'd6) |
                        (op == OP_LW) | (op == OP_SW) | (op == OP_LLB) | (op == OP_LHB);
      ex_flag_en_d    = FLAG_EN_MASK[op];
      ex_pcs_d        = (op == OP_PCS);
      ex_mem_read_d   = (op == OP_LW);
      ex_mem_write_d  = (op == OP_SW);
      ex_reg_write_d  = REGWR_MASK[op];
      ex_mem_to_reg_d = (op == OP_LW);
      ex_rd_d         = f_rd;
    end
  end

  // MEM and WB simply take the previous stage every cycle.
  always_comb begin
    mem_mem_read_d   = ex_mem_read_q;
    mem_mem_write_d  = ex_mem_write_q;
    mem_reg_write_d  = ex_reg_write_q;
    mem_mem_to_reg_d = ex_mem_to_reg_q;
    mem_rd_d         = ex_rd_q;
    wb_reg_write_d   = mem_reg_write_q;
    wb_mem_to_reg_d  = mem_mem_to_reg_q;
    wb_rd_d          = mem_rd_q;
  end

  // HLT sequencing: RUN -> DRAIN (count down) -> HALTED until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (halt_accept) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_INIT;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State and stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_RUN;
      cnt_q            <= '0;
      ex_alu_op_q      <= 4'h0;
      ex_alu_src_q     <= 1'b0;
      ex_flag_en_q     <= 1'b0;
      ex_pcs_q         <= 1'b0;
      ex_mem_read_q    <= 1'b0;
      ex_mem_write_q   <= 1'b0;
      ex_reg_write_q   <= 1'b0;
      ex_mem_to_reg_q  <= 1'b0;
      ex_rd_q          <= '0;
      mem_mem_read_q   <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_to_reg_q <= 1'b0;
      mem_rd_q         <= '0;
      wb_reg_write_q   <= 1'b0;
      wb_mem_to_reg_q  <= 1'b0;
      wb_rd_q          <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      ex_alu_op_q      <= ex_alu_op_d;
      ex_alu_src_q     <= ex_alu_src_d;
      ex_flag_en_q     <= ex_flag_en_d;
      ex_pcs_q         <= ex_pcs_d;
      ex_mem_read_q    <= ex_mem_read_d;
      ex_mem_write_q   <= ex_mem_write_d;
      ex_reg_write_q   <= ex_reg_write_d;
      ex_mem_to_reg_q  <= ex_mem_to_reg_d;
      ex_rd_q          <= ex_rd_d;
      mem_mem_read_q   <= mem_mem_read_d;
      mem_mem_write_q  <= mem_mem_write_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_mem_to_reg_q <= mem_mem_to_reg_d;
      mem_rd_q         <= mem_rd_d;
      wb_reg_write_q   <= wb_reg_write_d;
      wb_mem_to_reg_q  <= wb_mem_to_reg_d;
      wb_rd_q          <= wb_rd_d;
    end
  end

  assign ex_alu_op      = ex_alu_op_q;
  assign ex_alu_src     = ex_alu_src_q;
  assign ex_flag_en     = ex_flag_en_q;
  assign ex_pcs         = ex_pcs_q;
  assign ex_mem_read    = ex_mem_read_q;
  assign ex_mem_write   = ex_mem_write_q;
  assign ex_reg_write   = ex_reg_write_q;
  assign ex_mem_to_reg  = ex_mem_to_reg_q;
  assign ex_rd          = ex_rd_q;
  assign mem_mem_read   = mem_mem_read_q;
  assign mem_mem_write  = mem_mem_write_q;
  assign mem_reg_write  = mem_reg_write_q;
  assign mem_mem_to_reg = mem_mem_to_reg_q;
  assign mem_rd         = mem_rd_q;
  assign wb_reg_write   = wb_reg_write_q;
  assign wb_mem_to_reg  = wb_mem_to_reg_q;
  assign wb_rd          = wb_rd_q;
  assign halted         = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pipe_control.sv
// Directed testbench for pipe_control: inputs change on the falling edge,
// outputs are compared away from the rising edge.
module tb_pipe_control;

  logic        clk;
  logic        rst_n;
  logic [15:0] id_instr;
  logic        id_valid;
  logic        branch_taken;
  logic        id_rr1_sel, id_rr2_sel;
  logic [1:0]  id_imm_sel;
  logic        id_branch, id_branch_reg;
  logic        stall, flush, pc_hold;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src, ex_flag_en, ex_pcs;
  logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [3:0]  ex_rd;
  logic        mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg;
  logic [3:0]  mem_rd;
  logic        wb_reg_write, wb_mem_to_reg;
  logic [3:0]  wb_rd;
  logic        halted;

  int checks = 0;
  int errors = 0;

  pipe_control dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
    .branch_taken(branch_taken), .id_rr1_sel(id_rr1_sel), .id_rr2_sel(id_rr2_sel),
    .id_imm_sel(id_imm_sel), .id_branch(id_branch), .id_branch_reg(id_branch_reg),
    .stall(stall), .flush(flush), .pc_hold(pc_hold), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_flag_en(ex_flag_en), .ex_pcs(ex_pcs),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_rd(mem_rd), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one full cycle: returns on the next falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Present an instruction for the coming rising edge.
  task automatic drive(input logic [15:0] instr, input logic valid, input logic taken);
    id_instr     = instr;
    id_valid     = valid;
    branch_taken = taken;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(16'h0000, 1'b0, 1'b0);
    step();
    step();
    checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL rst_ex_reg_write got %b exp 0", ex_reg_write); end
    checks++; if (ex_rd !== 4'h0) begin errors++; $display("FAIL rst_ex_rd got %h exp 0", ex_rd); end
    checks++; if (mem_reg_write !== 1'b0) begin errors++; $display("FAIL rst_mem_reg_write got %b exp 0", mem_reg_write); end
    checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL rst_wb_reg_write got %b exp 0", wb_reg_write); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", halted); end
    checks++; if (pc_hold !== 1'b0) begin errors++; $display("FAIL rst_pc_hold got %b exp 0", pc_hold); end
    rst_n = 1'b1;
    $display("txn reset done");
  endtask

  task automatic test_alu_pipe();
    drive(16'h0123, 1'b1, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL add_stall got %b exp 0", stall); end
    checks++; if (id_imm_sel !== 2'b00) begin errors++; $display("FAIL add_imm_sel got %b exp 00", id_imm_sel); end
    step();
    drive(16'h0000, 1'b0, 1'b0);
    checks++; if (ex_reg_write !== 1'b1) begin errors++; $display("FAIL add_ex_reg_write got %b exp 1", ex_reg_write); end
    checks++; if (ex_flag_en !== 1'b1) begin errors++; $display("FAIL add_ex_flag_en got %b exp 1", ex_flag_en); end
    checks++; if (ex_alu_src !== 1'b0) begin errors++; $display("FAIL add_ex_alu_src got %b exp 0", ex_alu_src); end
    checks++; if (ex_rd !== 4'h1) begin errors++; $display("FAIL add_ex_rd got %h exp 1", ex_rd); end
    step();
    checks++; if (mem_reg_write !== 1'b1) begin errors++; $display("FAIL add_mem_reg_write got %b exp 1", mem_reg_write); end
    checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL add_wb_early got %b exp 0", wb_reg_write); end
    step();
    checks++; if (wb_reg_write !== 1'b1) begin errors++; $display("FAIL add_wb_reg_write got %b exp 1", wb_reg_write); end
    checks++; if (wb_rd !== 4'h1) begin errors++; $display("FAIL add_wb_rd got %h exp 1", wb_rd); end
    step();
    $display("txn add 0x0123 through pipeline");
  endtask

  task automatic test_load_use();
    drive(16'h8120, 1'b1, 1'b0);
    checks++; if (id_imm_sel !== 2'b01) begin errors++; $display("FAIL lw_imm_sel got %b exp 01", id_imm_sel); end
    step();
    drive(16'h0312, 1'b1, 1'b0);
    checks++; if (ex_mem_read !== 1'b1) begin errors++; $display("FAIL lw_ex_mem_read got %b exp 1", ex_mem_read); end
    checks++; if (ex_alu_src !== 1'b1) begin errors++; $display("FAIL lw_ex_alu_src got %b exp 1", ex_alu_src); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", stall); end
    checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL lu_pc_hold got %b exp 1", pc_hold); end
    step();
    checks++; if (ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_flag_en !== 1'b0) begin errors++; $display("FAIL lu_bubble got rw=%b mr=%b fe=%b exp 0 0 0", ex_reg_write, ex_mem_read, ex_flag_en); end
    checks++; if (ex_rd !== 4'h0) begin errors++; $display("FAIL lu_bubble_rd got %h exp 0", ex_rd); end
    checks++; if (mem_mem_read !== 1'b1) begin errors++; $display("FAIL lu_mem_mem_read got %b exp 1", mem_mem_read); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_once got %b exp 0", stall); end
    step();
    drive(16'h0000, 1'b0, 1'b0);
    checks++; if (ex_rd !== 4'h3 || ex_reg_write !== 1'b1) begin errors++; $display("FAIL lu_add_ex got rd=%h rw=%b exp 3 1", ex_rd, ex_reg_write); end
    checks++; if (wb_mem_to_reg !== 1'b1 || wb_rd !== 4'h1) begin errors++; $display("FAIL lu_wb_load got m2r=%b rd=%h exp 1 1", wb_mem_to_reg, wb_rd); end
    step();
    $display("txn lw 0x8120 then add 0x0312 stall");
  endtask

  task automatic test_no_overlap();
    drive(16'h8120, 1'b1, 1'b0);
    step();
    drive(16'h1345, 1'b1, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nolap_stall got %b exp 0", stall); end
    step();
    drive(16'h0000, 1'b0, 1'b0);
    checks++; if (ex_rd !== 4'h3 || ex_flag_en !== 1'b1) begin errors++; $display("FAIL nolap_sub_ex got rd=%h fe=%b exp 3 1", ex_rd, ex_flag_en); end
    step();
    // SW sources its data from instr[11:8]; LW to r1 then SW r1 must stall.
    drive(16'h8120, 1'b1, 1'b0);
    step();
    drive(16'h9100, 1'b1, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sw_stall got %b exp 1", stall); end
    checks++; if (id_rr2_sel !== 1'b1) begin errors++; $display("FAIL sw_rr2_sel got %b exp 1", id_rr2_sel); end
    step();
    drive(16'h0000, 1'b0, 1'b0);
    step();
    // LLB reads r2 through port 1; LW to r2 ahead of it must stall.
    drive(16'h8220, 1'b1, 1'b0);
    step();
    drive(16'hA2FF, 1'b1, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL llb_stall got %b exp 1", stall); end
    checks++; if (id_rr1_sel !== 1'b1 || id_imm_sel !== 2'b10) begin errors++; $display("FAIL llb_sel got rr1=%b imm=%b exp 1 10", id_rr1_sel, id_imm_sel); end
    step();
    drive(16'h0000, 1'b0, 1'b0);
    step();
    $display("txn no-overlap sub, sw and llb hazards");
  endtask

  task automatic test_branch();
    drive(16'hC005, 1'b1, 1'b1);
    checks++; if (flush !== 1'b1 || id_branch !== 1'b1) begin errors++; $display("FAIL b_taken got flush=%b br=%b exp 1 1", flush, id_branch); end
    step();
    drive(16'hC005, 1'b1, 1'b0);
    checks++; if (ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0 || ex_flag_en !== 1'b0 || ex_mem_read !== 1'b0) begin errors++; $display("FAIL b_ex_enables got rw=%b mw=%b fe=%b mr=%b exp 0", ex_reg_write, ex_mem_write, ex_flag_en, ex_mem_read); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL b_not_taken got %b exp 0", flush); end
    drive(16'hC005, 1'b0, 1'b1);
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL b_invalid got %b exp 0", flush); end
    step();
    $display("txn b 0xC005 taken/not-taken");
  endtask

  task automatic test_branch_stall();
    drive(16'h8120, 1'b1, 1'b0);
    step();
    drive(16'hD010, 1'b1, 1'b1);
    checks++; if (stall !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL br_cyc1 got stall=%b flush=%b exp 1 0", stall, flush); end
    checks++; if (id_branch_reg !== 1'b1) begin errors++; $display("FAIL br_decode got %b exp 1", id_branch_reg); end
    step();
    checks++; if (stall !== 1'b0 || flush !== 1'b1) begin errors++; $display("FAIL br_cyc2 got stall=%b flush=%b exp 0 1", stall, flush); end
    step();
    drive(16'h0000, 1'b0, 1'b0);
    step();
    $display("txn br 0xD010 behind lw r1");
  endtask

  task automatic test_halt();
    drive(16'hF000, 1'b1, 1'b0);
    checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL hlt_pc_hold got %b exp 1", pc_hold); end
    step();
    drive(16'h0123, 1'b1, 1'b0);
    checks++; if (ex_reg_write !== 1'b0 || ex_rd !== 4'h0) begin errors++; $display("FAIL hlt_bubble got rw=%b rd=%h exp 0 0", ex_reg_write, ex_rd); end
    checks++; if (halted !== 1'b0 || pc_hold !== 1'b1) begin errors++; $display("FAIL hlt_drain1 got halted=%b hold=%b exp 0 1", halted, pc_hold); end
    step();
    checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL hlt_drain_gated got %b exp 0", ex_reg_write); end
    step();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hlt_drain3 got %b exp 0", halted); end
    step();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hlt_halted got %b exp 1", halted); end
    drive(16'hC005, 1'b1, 1'b1);
    checks++; if (flush !== 1'b0 || pc_hold !== 1'b1) begin errors++; $display("FAIL hlt_quiet got flush=%b hold=%b exp 0 1", flush, pc_hold); end
    step();
    step();
    checks++; if (halted !== 1'b1 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL hlt_sticky got halted=%b rw=%b exp 1 0", halted, ex_reg_write); end
    $display("txn hlt 0xF000 drain and halt");
  endtask

  task automatic test_reset_mid_drain();
    rst_n = 1'b0;
    drive(16'h0000, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rstd_clear got %b exp 0", halted); end
    drive(16'hF000, 1'b1, 1'b0);
    step();
    drive(16'h0000, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(16'h0000, 1'b0, 1'b0);
    checks++; if (halted !== 1'b0 || pc_hold !== 1'b0) begin errors++; $display("FAIL rstd_run got halted=%b hold=%b exp 0 0", halted, pc_hold); end
    drive(16'h0123, 1'b1, 1'b0);
    step();
    drive(16'h0000, 1'b0, 1'b0);
    checks++; if (ex_reg_write !== 1'b1) begin errors++; $display("FAIL rstd_decode got %b exp 1", ex_reg_write); end
    step();
    step();
    step();
    step();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rstd_no_halt got %b exp 0", halted); end
    $display("txn reset mid-drain");
  endtask

  initial begin
    rst_n        = 1'b0;
    id_instr     = 16'h0000;
    id_valid     = 1'b0;
    branch_taken = 1'b0;
    test_reset();
    test_alu_pipe();
    test_load_use();
    test_no_overlap();
    test_branch();
    test_branch_stall();
    test_halt();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_control.md
Name: pipe_control

Overview:
- Pipelined successor to the single-cycle WISC-S25 control decoder.
- Decodes the IF/ID instruction into control bits and carries them through registered EX/MEM/WB control stages.
- Detects load-use hazards and inserts bubbles; squashes on taken branch.
- Sequences HLT through a pipeline-drain state machine. Sits between the IF/ID register and the datapath stage registers.

Parameters:
- REG_W, 4, register-specifier width (instr fields rd/rs/rt).
- PIPE_DRAIN, 3, cycles after HLT decode before halted asserts (EX, MEM, WB drain).
- FLAG_EN_MASK, 16'h0077, bit n set: opcode n writes flags (ADD, SUB, XOR, SLL, SRA, ROR).
- REGWR_MASK, 16'h4DFF, bit n set: opcode n writes the register file (0-7, LW, LLB, LHB, PCS).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- id_instr  in  16  instruction in IF/ID
- id_valid  in  1  IF/ID holds a real instruction
- branch_taken  in  1  ID-stage B/BR condition true (from flag compare)
- id_rr1_sel  out  1  1: read port 1 uses instr[11:8] (LLB/LHB)
- id_rr2_sel  out  1  1: read port 2 uses instr[11:8] (SW)
- id_imm_sel  out  2  00 imm4, 01 SE offset<<1 (LW/SW), 10 ZE imm8 (LLB/LHB)
- id_branch  out  1  B decoded and valid
- id_branch_reg  out  1  BR decoded and valid
- stall  out  1  hold PC and IF/ID; bubble into EX
- flush  out  1  squash IF/ID next cycle
- pc_hold  out  1  freeze PC (stall, drain or halted)
- ex_alu_op  out  4  opcode in EX
- ex_alu_src  out  1  1: immediate operand
- ex_flag_en  out  1  flag register write enable
- ex_pcs  out  1  write PC+2 to rd
- ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1 each
- ex_rd  out  REG_W  destination in EX
- mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg  out  1 each
- mem_rd  out  REG_W
- wb_reg_write, wb_mem_to_reg  out  1 each
- wb_rd  out  REG_W
- halted  out  1  sticky; processor stopped

Behaviour:
- Decode (combinational, op = id_instr[15:12]):
  - Decode is gated by eff_valid = id_valid & state==RUN.
  - mem_read = op==1000; mem_write = op==1001; mem_to_reg = mem_read.
  - alu_src = 1 for 0100/0101/0110/1000-1011.
  - flag_en = FLAG_EN_MASK[op]; reg_write = REGWR_MASK[op]; pcs = op==1110.
  - rd = instr[11:8].
- Source use:
  - rs = instr[7:4] used by ops 0-9 and BR.
  - rt = instr[3:0] used by 0000/0001/0010/0011/0111.
  - instr[11:8] used by SW, LLB and LHB.
- Load-use stall: stall = eff_valid & ex_mem_read & (ex_rd equals any used source). r0 is not special-cased.
- Stall effects: EX control register loads all-zero enables (bubble); ex_rd loads 0.
- Stage registers: EX<=decode (or bubble); MEM<=EX; WB<=MEM, every cycle. There is no global enable, so a stall does not freeze downstream stages.
- Branches: flush = eff_valid & ~stall & (id_branch | id_branch_reg) & branch_taken. Stall has priority, so flush is suppressed in a stall cycle and re-evaluated next cycle.
- B/BR/HLT write nothing: all EX enables are 0.
- FSM RUN:
  - HLT (op 1111) with eff_valid & ~stall -> DRAIN, cnt<=PIPE_DRAIN-1.
  - HLT enters EX as a bubble.
- FSM DRAIN:
  - Decode forced invalid (bubbles); cnt decrements each cycle.
  - When cnt==0 -> HALTED.
- FSM HALTED: halted=1, bubbles only, held until reset.
- pc_hold = stall | state!=RUN | (HLT with eff_valid & ~stall). The PC freezes in the HLT decode cycle and does not advance past HLT.
- Reset (rst_n low at edge):
  - state=RUN, cnt=0.
  - All ex_/mem_/wb_ registers 0, halted=0.
  - Reset mid-drain aborts the drain.
  - Combinational outputs follow inputs with state=RUN.
- Latency: decode-to-EX 1 cycle, EX-to-MEM 1, MEM-to-WB 1.
- PIPE_DRAIN=1: HALTED one cycle after HLT decode.

Test Plan:
- Reset, then ADD 0x0123 valid -> next cycle ex_reg_write=1, ex_flag_en=1, ex_alu_src=0, ex_rd=1. wb_reg_write=1 three cycles after decode.
- LW 0x8120 then ADD 0x0312 (rs=1) -> stall=1 for exactly one cycle and EX receives a bubble (all enables 0). The ADD then reaches EX with ex_rd=3.
- LW 0x8120 then SUB 0x1345 (no overlap) -> stall stays 0.
- B 0xC005 with branch_taken=1 -> flush=1 in the same cycle and all EX enables 0 next cycle. With branch_taken=0, flush=0.
- BR 0xD010 behind LW to r1 with branch_taken=1 -> cycle 1: stall=1, flush=0. Cycle 2: flush=1.
- HLT 0xF000 -> pc_hold=1 immediately and halted=1 after 3 cycles (PIPE_DRAIN=3), sticky. Asserting rst_n=0 mid-drain -> halted=0 and state RUN.
